// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with clock inhibit, request-to-send, odd parity and ACK check
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES  = 12000,
  parameter int START_TO_CYCLES = 1500000,
  parameter int BIT_TO_CYCLES   = 20000,
  parameter int FILTER_LEN      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int M1   = INHIBIT_CYCLES > BIT_TO_CYCLES ? INHIBIT_CYCLES : BIT_TO_CYCLES;
  localparam int MAXC = M1 > START_TO_CYCLES ? M1 : START_TO_CYCLES;
  localparam int CW   = $clog2(MAXC + 2);
  localparam int FW   = $clog2(FILTER_LEN + 1);
  typedef enum logic [3:0] {IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE, ERROR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic clk_s1, clk_s2, dat_s1, dat_s2, clk_f, fall;
  logic [7:0] data_q;
  logic [2:0] idx;
  logic par_q, ack_q, cnt_clr, bit_wd;
  logic [1:0] err_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {clk_s1, clk_s2, dat_s1, dat_s2, clk_f} <= '1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_f) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_s2;
        fcnt  <= '0;
        fall  <= clk_f;
      end else fcnt <= fcnt + 1'b1;
    end
  assign bit_wd = cnt >= CW'(BIT_TO_CYCLES);
  always_comb begin
    state_n = state;
    err_n   = 2'b10;
    cnt_clr = 1'b0;
    case (state)
      IDLE:      state_n = tx_valid ? INHIBIT : IDLE;
      INHIBIT:   state_n = cnt >= CW'(INHIBIT_CYCLES) ? RTS : INHIBIT;
      RTS: begin
        err_n   = 2'b01;
        state_n = fall ? DATA : (cnt >= CW'(START_TO_CYCLES) ? ERROR : RTS);
      end
      DATA: begin
        cnt_clr = fall;
        state_n = fall ? (idx == 3'd7 ? PARITY : DATA) : (bit_wd ? ERROR : DATA);
      end
      PARITY: begin
        cnt_clr = fall;
        state_n = fall ? STOP : (bit_wd ? ERROR : PARITY);
      end
      STOP: begin
        cnt_clr = fall;
        state_n = fall ? ACK : (bit_wd ? ERROR : STOP);
      end
      ACK: begin
        err_n   = 2'b11;
        state_n = ack_q ? ERROR : WAIT_IDLE;
      end
      WAIT_IDLE: state_n = (clk_f && dat_s2) ? IDLE : (bit_wd ? ERROR : WAIT_IDLE);
      ERROR:     state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      idx      <= '0;
      ack_q    <= 1'b1;
      err_code <= 2'b00;
    end else begin
      state <= state_n;
      if (state_n != state || cnt_clr) cnt <= '0;
      else if (!(&cnt)) cnt <= cnt + 1'b1;
      if (state == IDLE && tx_valid) begin
        data_q   <= tx_data;
        par_q    <= ~^tx_data;
        idx      <= '0;
        err_code <= 2'b00;
      end
      if (state == DATA && fall && idx != 3'd7) idx <= idx + 1'b1;
      if (state == STOP && fall) ack_q <= dat_s2;
      if (state_n == ERROR && state != ERROR) err_code <= err_n;
    end
  // line drive decodes registered state, so data moves only in the cycle after a fall strobe
  assign tx_ready    = state == IDLE;
  assign tx_busy     = state != IDLE;
  assign tx_done     = state == WAIT_IDLE && clk_f && dat_s2;
  assign tx_err      = state == ERROR;
  assign ps2_clk_oe  = state == INHIBIT;
  assign ps2_data_oe = (state == INHIBIT && cnt >= CW'(INHIBIT_CYCLES)) || state == RTS ||
                       (state == DATA && !data_q[idx]) || (state == PARITY && !par_q);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device BFM on open-drain PS/2 lines with queued expected bits and outcomes
module tb_ps2_host_tx;
  localparam int INH = 100, STO = 600, BTO = 300;
  logic clk = 1'b0, reset_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic [1:0] err_code;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  int checks = 0, passed = 0, cyc = 0, last_fall = 0, res_cyc = 0;
  logic exp_bits[$];
  int exp_res[$];
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TO_CYCLES(STO), .BIT_TO_CYCLES(BTO), .FILTER_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic issue(input logic [7:0] b, input int code);
    int n;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
    exp_res.push_back(code);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = ~b;
    n = 0;
    while (ps2_clk_oe && n < INH + 10) begin n++; @(negedge clk); end
    checks++; if (n < INH || n > INH + 2) $display("FAIL inhibit_len: got %0d cycles want %0d..%0d", n, INH, INH + 2); else passed++;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) $display("FAIL rts: clk_oe %b data_oe %b want 0 1", ps2_clk_oe, ps2_data_oe); else passed++;
  endtask
  task automatic dev_clock(input int nf, input bit ack);
    logic e;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= nf; k++) begin
      repeat (30) @(negedge clk);
      checks++;
      if (exp_bits.size() == 0) $display("FAIL line_bit%0d: got %b want nothing queued", k, ps2_data_in);
      else begin
        e = exp_bits.pop_front();
        if (ps2_data_in !== e) $display("FAIL line_bit%0d: got %b want %b", k, ps2_data_in, e); else passed++;
      end
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask
  task automatic wait_result(input int bound);
    int n, e, got;
    n = 0;
    while (!(tx_done === 1'b1 || tx_err === 1'b1) && n < bound) begin @(negedge clk); n++; end
    res_cyc = cyc;
    checks++;
    if (n >= bound) $display("FAIL result_timeout: no tx_done/tx_err within %0d cycles", bound);
    else begin
      e = exp_res.size() ? exp_res.pop_front() : -1;
      got = tx_done ? 0 : int'(err_code);
      if (got !== e || tx_ready !== 1'b0 || (tx_done && tx_err))
        $display("FAIL result: got code %0d done %b err %b ready %b want code %0d ready 0", got, tx_done, tx_err, tx_ready, e);
      else passed++;
    end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL released: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); else passed++;
    n = 0;
    repeat (30) begin @(negedge clk); if (tx_done || tx_err) n++; end
    checks++; if (n != 0) $display("FAIL single_pulse: got %0d extra pulses want 0", n); else passed++;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0 || err_code !== 2'b00 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
      $display("FAIL reset: ready %b busy %b done %b err %b code %b oe %b%b want 1 0 0 0 00 00", tx_ready, tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_data_oe);
    else passed++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_frame(input logic [7:0] b);
    issue(b, 0);
    fork
      dev_clock(11, 1'b1);
      wait_result(4000);
    join
  endtask
  task automatic test_start_timeout;
    int t0;
    issue(8'h12, 1);
    t0 = cyc;
    wait_result(3000);
    checks++; if (res_cyc - t0 != STO + 1) $display("FAIL start_to_delay: got %0d want %0d", res_cyc - t0, STO + 1); else passed++;
    checks++; if (err_code !== 2'b01) $display("FAIL err_code_hold: got %b want 01", err_code); else passed++;
    exp_bits.delete();
  endtask
  task automatic test_bit_timeout;
    issue(8'hA5, 2);
    fork
      dev_clock(4, 1'b0);
      wait_result(4000);
    join
    checks++;
    if (res_cyc - last_fall <= BTO || res_cyc - last_fall > BTO + 20)
      $display("FAIL bit_to_delay: got %0d want %0d..%0d", res_cyc - last_fall, BTO + 1, BTO + 20);
    else passed++;
    exp_bits.delete();
    test_frame(8'h3C);
  endtask
  task automatic test_no_ack;
    int n;
    issue(8'hF0, 3);
    @(negedge clk);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    fork
      dev_clock(11, 1'b0);
      wait_result(4000);
    join
    n = 0;
    repeat (50) begin @(negedge clk); if (ps2_clk_oe || !tx_ready) n++; end
    checks++; if (n != 0) $display("FAIL busy_ignore: got %0d non-idle cycles want 0", n); else passed++;
    checks++; if (err_code !== 2'b11) $display("FAIL err_code_hold: got %b want 11", err_code); else passed++;
  endtask
  task automatic test_glitch;
    issue(8'h01, 0);
    dev_clk_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) $display("FAIL glitch: data_oe %b clk_oe %b want 1 0", ps2_data_oe, ps2_clk_oe); else passed++;
    fork
      dev_clock(11, 1'b1);
      wait_result(4000);
    join
  endtask
  task automatic test_async_reset;
    issue(8'h00, 0);
    dev_clock(3, 1'b0);
    checks++; if (ps2_data_oe !== 1'b1 || tx_busy !== 1'b1) $display("FAIL mid_data: data_oe %b busy %b want 1 1", ps2_data_oe, tx_busy); else passed++;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL async_reset: clk_oe %b data_oe %b ready %b want 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    exp_bits.delete();
    exp_res.delete();
    repeat (5) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_frame(8'hED);
    test_frame(8'hFF);
    test_frame(8'h00);
    test_frame(8'h01);
    test_start_timeout;
    test_bit_timeout;
    test_no_ack;
    test_glitch;
    test_async_reset;
    test_frame(8'h96);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
